decode_stage_hs: RTL and testbench
==================================

DECODE_STAGE_HS -- requirements
Module: decode_stage_hs

Interface
REQ-001 Parameter FWD_EN, default 1: 1 = forwarding present, only load-use stalls; 0 = stall on any RAW hit against EXE/MEM.
REQ-002 Parameter MD_EN, default 1: 1 = HI/LO and mult/div support present; 0 = those opcodes raise reserved-instruction.
REQ-003 Parameter EXC_W, default 6: exception vector width; bit map {int, adel, ri, ov, sys, brk} for bits 5..0.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 fe_valid, fe_inst[31:0], fe_pc[31:0]  in  instruction offer from fetch.
REQ-007 de_allowin  out  1  decode can accept this cycle.
REQ-008 rs_addr[4:0], rt_addr[4:0] out; rs_data[31:0], rt_data[31:0] in  (forwarded operands).
REQ-009 exe_valid, exe_is_load, exe_waddr[4:0], mem_valid, mem_waddr[4:0]  in  hazard inputs.
REQ-010 wb_md_complete in 1, wb_md_result[63:0] in  mult/div completion.
REQ-011 exe_allowin  in  1  downstream ready.
REQ-012 de_to_exe_valid  out  1; de_bus[W-1:0]  out  registered control/operand bundle.
REQ-013 de_md_busy  out  1  mult/div in flight.
REQ-014 exc_flush  in  1  pipeline flush on exception/ERET.

Function
REQ-015 Combinational decode SHALL be done by sub-module inst_decoder; this block owns all state.
REQ-016 de_valid register: SHALL be set on (fe_valid & de_allowin), cleared when the held instruction leaves and no new one is accepted.
REQ-017 de_allowin = !de_valid | (de_ready_go & exe_allowin).
REQ-018 de_to_exe_valid = de_valid & de_ready_go & !exc_flush.
REQ-019 de_ready_go SHALL be 0 on: load-use hit (exe_valid & exe_is_load & exe_waddr!=0 & exe_waddr matches a used source); FWD_EN=0 and any EXE/MEM waddr hit; MFHI/MFLO while de_md_busy.
REQ-020 Register $0 SHALL never cause a hazard.
REQ-021 Issue of MULT/MULTU/DIV/DIVU (handshake fire) SHALL set de_md_busy; wb_md_complete SHALL clear it and load {HI,LO} from wb_md_result in the same edge.
REQ-022 Mult/div issue while de_md_busy SHALL stall (one operation in flight).
REQ-023 MTHI/MTLO SHALL write HI/LO from rs_data only on handshake fire; simultaneous wb_md_complete SHALL take priority.
REQ-024 Delay-slot flag SHALL be set for the instruction accepted immediately after a fired branch/jump; cleared otherwise; travels in de_bus.
REQ-025 Exception bits SHALL be latched with the instruction: adel = fe_pc[1:0]!=0; ri = undecoded opcode; sys; brk; int=0; ov = ADD/ADDI/SUB flag.
REQ-026 Any exception bit set SHALL clear reg/mem/md enables in de_bus; the instruction still flows downstream.
REQ-027 exc_flush SHALL clear de_valid and the delay-slot flag next edge and suppress de_to_exe_valid in the same cycle; it SHALL NOT clear de_md_busy or HI/LO.
REQ-028 exc_flush with fe_valid in the same cycle: the offered instruction SHALL be discarded.
REQ-029 Output bundle latency: one cycle from accept to de_to_exe_valid when no stall.

Reset
REQ-030 resetn low SHALL immediately clear de_valid, de_md_busy, delay-slot flag, HI, LO and de_bus to zero; de_allowin=1 after release.
REQ-031 Reset mid mult/div SHALL drop the pending completion state; a later wb_md_complete with de_md_busy=0 SHALL still update HI/LO.

Structure
REQ-032 Shared package SHALL hold aluop, branch-type, load-type, store-type codes, exception bit indices and de_bus field offsets.
REQ-033 One sub-module: inst_decoder (combinational, opcode -> control bundle).

Verification
REQ-034 ADDU after LW writing $5 reading $5, exe_is_load=1 -> de_to_exe_valid=0 one cycle, then fires; no stall with exe_waddr=0.
REQ-035 MULT fires, MFLO follows -> stalls until wb_md_complete with result 0x0000_0002_0000_0003; MFLO src value 0x3.
REQ-036 BEQ then ADDIU accepted -> ADDIU delay-slot flag 1; next instruction flag 0.
REQ-037 fe_pc=0x...02 -> adel=1, reg_en=0 in de_bus; opcode 0x3F -> ri=1.
REQ-038 exc_flush while de_valid=1 and fe_valid=1 -> no de_to_exe_valid that cycle, de_valid=0 next cycle.
REQ-039 resetn asserted mid-stall -> all outputs zero without clk edge; de_allowin=1 after release.

Source files
------------

// File: rtl/decode_stage_hs_pkg.sv
// Shared decode-stage types: opcode tables, control bundle and de_bus layout.
// Imported by the decoder and the decode stage.
package decode_stage_hs_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } aluop_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ,
    BR_BGTZ, BR_J, BR_JR
  } br_e;

  typedef enum logic [2:0] {
    LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW
  } ld_e;

  typedef enum logic [1:0] {
    ST_NONE, ST_SB, ST_SH, ST_SW
  } st_e;

  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
    MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
  } md_e;

  localparam int EXC_INT  = 5;
  localparam int EXC_ADEL = 4;
  localparam int EXC_RI   = 3;
  localparam int EXC_OV   = 2;
  localparam int EXC_SYS  = 1;
  localparam int EXC_BRK  = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    aluop_e      aluop;
    br_e         br;
    ld_e         ld;
    st_e         st;
    md_e         md;
    logic        use_rs;
    logic        use_rt;
    logic        reg_en;
    logic [4:0]  waddr;
    logic [31:0] imm;
    logic        ri;
    logic        sys;
    logic        brk;
    logic        ov;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    aluop_e      aluop;
    br_e         br;
    ld_e         ld;
    st_e         st;
    md_e         md;
    logic [4:0]  waddr;
    logic        reg_en;
    logic        ds;
    logic [5:0]  exc;
  } de_bus_t;

  localparam int EXC_LSB   = 0;
  localparam int DS_BIT    = 6;
  localparam int REGEN_BIT = 7;
  localparam int WADDR_LSB = 8;
  localparam int MD_LSB    = 13;
  localparam int ST_LSB    = 17;
  localparam int LD_LSB    = 19;
  localparam int BR_LSB    = 22;
  localparam int ALU_LSB   = 25;
  localparam int IMM_LSB   = 29;
  localparam int SRC2_LSB  = 61;
  localparam int SRC1_LSB  = 93;
  localparam int PC_LSB    = 125;
  localparam int DE_BUS_W  = $bits(de_bus_t);

  function automatic logic is_md_arith(md_e m);
    return (m == MD_MULT) | (m == MD_MULTU) |
           (m == MD_DIV)  | (m == MD_DIVU);
  endfunction

endpackage

// File: rtl/decode_stage_hs_inst_decoder.sv
// Combinational MIPS-I opcode decoder for the decode stage.
// Pure function of the instruction word; holds no state.
module inst_decoder
  import decode_stage_hs_pkg::*;
#(
  parameter int MD_EN = 1
) (
  input  logic [31:0]       i_inst,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rt, w_rd;
  logic [31:0] w_sext, w_zext, w_sa, w_tgt;
  ctrl_t       w_c;

  assign w_op   = i_inst[31:26];
  assign w_fn   = i_inst[5:0];
  assign w_rt   = i_inst[20:16];
  assign w_rd   = i_inst[15:11];
  assign w_sext = {{16{i_inst[15]}}, i_inst[15:0]};
  assign w_zext = {16'h0, i_inst[15:0]};
  assign w_sa   = {27'h0, i_inst[10:6]};
  assign w_tgt  = {6'h0, i_inst[25:0]};

  function automatic ctrl_t f_imm(
    aluop_e op, logic [4:0] rt, logic [31:0] imm
  );
    ctrl_t c;
    c        = '0;
    c.aluop  = op;
    c.use_rs = 1'b1;
    c.reg_en = 1'b1;
    c.waddr  = rt;
    c.imm    = imm;
    return c;
  endfunction

  always_comb begin
    w_c = '0;
    unique case (1'b1)
      w_op == OP_SPECIAL: begin
        w_c.use_rs = 1'b1;
        w_c.use_rt = 1'b1;
        w_c.reg_en = 1'b1;
        w_c.waddr  = w_rd;
        unique case (1'b1)
          w_fn == 6'h20: begin w_c.aluop = ALU_ADD; w_c.ov = 1'b1; end
          w_fn == 6'h21: w_c.aluop = ALU_ADD;
          w_fn == 6'h22: begin w_c.aluop = ALU_SUB; w_c.ov = 1'b1; end
          w_fn == 6'h23: w_c.aluop = ALU_SUB;
          w_fn == 6'h24: w_c.aluop = ALU_AND;
          w_fn == 6'h25: w_c.aluop = ALU_OR;
          w_fn == 6'h26: w_c.aluop = ALU_XOR;
          w_fn == 6'h27: w_c.aluop = ALU_NOR;
          w_fn == 6'h2a: w_c.aluop = ALU_SLT;
          w_fn == 6'h2b: w_c.aluop = ALU_SLTU;
          w_fn == 6'h00: begin
            w_c.aluop = ALU_SLL; w_c.use_rs = 1'b0; w_c.imm = w_sa;
          end
          w_fn == 6'h02: begin
            w_c.aluop = ALU_SRL; w_c.use_rs = 1'b0; w_c.imm = w_sa;
          end
          w_fn == 6'h03: begin
            w_c.aluop = ALU_SRA; w_c.use_rs = 1'b0; w_c.imm = w_sa;
          end
          w_fn == 6'h08: begin
            w_c.br = BR_JR; w_c.use_rt = 1'b0; w_c.reg_en = 1'b0;
          end
          w_fn == 6'h09: begin w_c.br = BR_JR; w_c.use_rt = 1'b0; end
          w_fn == 6'h0c: begin w_c.sys = 1'b1; w_c.reg_en = 1'b0; end
          w_fn == 6'h0d: begin w_c.brk = 1'b1; w_c.reg_en = 1'b0; end
          w_fn == 6'h10: begin
            w_c.md = MD_MFHI; w_c.use_rs = 1'b0; w_c.use_rt = 1'b0;
          end
          w_fn == 6'h12: begin
            w_c.md = MD_MFLO; w_c.use_rs = 1'b0; w_c.use_rt = 1'b0;
          end
          w_fn == 6'h11: begin
            w_c.md = MD_MTHI; w_c.use_rt = 1'b0; w_c.reg_en = 1'b0;
          end
          w_fn == 6'h13: begin
            w_c.md = MD_MTLO; w_c.use_rt = 1'b0; w_c.reg_en = 1'b0;
          end
          w_fn == 6'h18: begin w_c.md = MD_MULT;  w_c.reg_en = 1'b0; end
          w_fn == 6'h19: begin w_c.md = MD_MULTU; w_c.reg_en = 1'b0; end
          w_fn == 6'h1a: begin w_c.md = MD_DIV;   w_c.reg_en = 1'b0; end
          w_fn == 6'h1b: begin w_c.md = MD_DIVU;  w_c.reg_en = 1'b0; end
          default: begin w_c = '0; w_c.ri = 1'b1; end
        endcase
      end
      w_op == OP_ADDI: begin
        w_c = f_imm(ALU_ADD, w_rt, w_sext); w_c.ov = 1'b1;
      end
      w_op == OP_ADDIU: w_c = f_imm(ALU_ADD,  w_rt, w_sext);
      w_op == OP_SLTI:  w_c = f_imm(ALU_SLT,  w_rt, w_sext);
      w_op == OP_SLTIU: w_c = f_imm(ALU_SLTU, w_rt, w_sext);
      w_op == OP_ANDI:  w_c = f_imm(ALU_AND,  w_rt, w_zext);
      w_op == OP_ORI:   w_c = f_imm(ALU_OR,   w_rt, w_zext);
      w_op == OP_XORI:  w_c = f_imm(ALU_XOR,  w_rt, w_zext);
      w_op == OP_LUI: begin
        w_c = f_imm(ALU_LUI, w_rt, w_zext); w_c.use_rs = 1'b0;
      end
      w_op == OP_LB:  begin w_c = f_imm(ALU_ADD, w_rt, w_sext); w_c.ld = LD_LB;  end
      w_op == OP_LH:  begin w_c = f_imm(ALU_ADD, w_rt, w_sext); w_c.ld = LD_LH;  end
      w_op == OP_LW:  begin w_c = f_imm(ALU_ADD, w_rt, w_sext); w_c.ld = LD_LW;  end
      w_op == OP_LBU: begin w_c = f_imm(ALU_ADD, w_rt, w_sext); w_c.ld = LD_LBU; end
      w_op == OP_LHU: begin w_c = f_imm(ALU_ADD, w_rt, w_sext); w_c.ld = LD_LHU; end
      w_op inside {OP_SB, OP_SH, OP_SW}: begin
        w_c        = f_imm(ALU_ADD, w_rt, w_sext);
        w_c.reg_en = 1'b0;
        w_c.use_rt = 1'b1;
        w_c.st     = (w_op == OP_SB) ? ST_SB :
                     (w_op == OP_SH) ? ST_SH : ST_SW;
      end
      w_op inside {OP_BEQ, OP_BNE}: begin
        w_c.use_rs = 1'b1;
        w_c.use_rt = 1'b1;
        w_c.imm    = w_sext;
        w_c.br     = (w_op == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      w_op inside {OP_BLEZ, OP_BGTZ}: begin
        w_c.use_rs = 1'b1;
        w_c.imm    = w_sext;
        w_c.br     = (w_op == OP_BLEZ) ? BR_BLEZ : BR_BGTZ;
      end
      w_op == OP_J: begin w_c.br = BR_J; w_c.imm = w_tgt; end
      w_op == OP_JAL: begin
        w_c.br = BR_J; w_c.imm = w_tgt;
        w_c.reg_en = 1'b1; w_c.waddr = 5'd31;
      end
      default: w_c.ri = 1'b1;
    endcase
    // Without a HI/LO unit the whole mult/div group is reserved.
    if (MD_EN == 0 && w_c.md != MD_NONE) begin
      w_c.md = MD_NONE;
      w_c.ri = 1'b1;
    end
  end

  assign o_ctrl = w_c;

endmodule

// File: rtl/decode_stage_hs.sv
// Decode pipeline stage: holds one instruction, resolves hazards,
// owns HI/LO and mult/div busy state, and hands off de_bus to EXE.
module decode_stage_hs
  import decode_stage_hs_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int MD_EN  = 1,
  parameter int EXC_W  = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                fe_valid,
  input  logic [31:0]         fe_inst,
  input  logic [31:0]         fe_pc,
  output logic                de_allowin,
  output logic [4:0]          rs_addr,
  output logic [4:0]          rt_addr,
  input  logic [31:0]         rs_data,
  input  logic [31:0]         rt_data,
  input  logic                exe_valid,
  input  logic                exe_is_load,
  input  logic [4:0]          exe_waddr,
  input  logic                mem_valid,
  input  logic [4:0]          mem_waddr,
  input  logic                wb_md_complete,
  input  logic [63:0]         wb_md_result,
  input  logic                exe_allowin,
  output logic                de_to_exe_valid,
  output logic [DE_BUS_W-1:0] de_bus,
  output logic                de_md_busy,
  input  logic                exc_flush
);

  logic              r_valid, r_md_busy, r_ds, r_br_pend;
  logic [31:0]       r_inst, r_pc, r_hi, r_lo;
  logic [CTRL_W-1:0] w_ctrl_raw;
  ctrl_t             w_ctrl;
  logic [EXC_W-1:0]  w_exc;
  logic              w_exc_any, w_exe_hit, w_mem_hit;
  logic              w_stall, w_ready_go, w_fire, w_accept, w_br;
  md_e               w_md;
  de_bus_t           w_bus;

  inst_decoder #(.MD_EN(MD_EN)) u_dec (
    .i_inst (r_inst),
    .o_ctrl (w_ctrl_raw)
  );

  assign w_ctrl  = ctrl_t'(w_ctrl_raw);
  assign rs_addr = r_inst[25:21];
  assign rt_addr = r_inst[20:16];

  always_comb begin
    w_exc           = '0;
    w_exc[EXC_ADEL] = (r_pc[1:0] != 2'b00);
    w_exc[EXC_RI]   = w_ctrl.ri;
    w_exc[EXC_OV]   = w_ctrl.ov;
    w_exc[EXC_SYS]  = w_ctrl.sys;
    w_exc[EXC_BRK]  = w_ctrl.brk;
  end

  // ov only arms the EXE overflow trap, so it does not squash enables.
  assign w_exc_any = w_exc[EXC_INT] | w_exc[EXC_ADEL] | w_exc[EXC_RI] |
                     w_exc[EXC_SYS] | w_exc[EXC_BRK];
  assign w_md      = w_exc_any ? MD_NONE : w_ctrl.md;

  assign w_exe_hit = exe_valid & (exe_waddr != 5'd0) &
                     ((w_ctrl.use_rs & (exe_waddr == rs_addr)) |
                      (w_ctrl.use_rt & (exe_waddr == rt_addr)));
  assign w_mem_hit = mem_valid & (mem_waddr != 5'd0) &
                     ((w_ctrl.use_rs & (mem_waddr == rs_addr)) |
                      (w_ctrl.use_rt & (mem_waddr == rt_addr)));

  assign w_stall = (w_exe_hit & exe_is_load) |
                   ((FWD_EN == 0) & (w_exe_hit | w_mem_hit)) |
                   (r_md_busy & (is_md_arith(w_md) |
                    (w_md == MD_MFHI) | (w_md == MD_MFLO)));

  assign w_ready_go      = ~w_stall;
  assign de_allowin      = resetn & (~r_valid | (w_ready_go & exe_allowin));
  assign de_to_exe_valid = r_valid & w_ready_go & ~exc_flush;
  assign w_fire          = de_to_exe_valid & exe_allowin;
  assign w_accept        = fe_valid & de_allowin & ~exc_flush;
  assign w_br            = (w_ctrl.br != BR_NONE);
  assign de_md_busy      = r_md_busy;

  always_comb begin
    w_bus = '0;
    if (r_valid) begin
      w_bus.pc     = r_pc;
      w_bus.src1   = (w_md == MD_MFHI) ? r_hi :
                     (w_md == MD_MFLO) ? r_lo : rs_data;
      w_bus.src2   = rt_data;
      w_bus.imm    = w_ctrl.imm;
      w_bus.aluop  = w_ctrl.aluop;
      w_bus.br     = w_ctrl.br;
      w_bus.ld     = w_exc_any ? LD_NONE : w_ctrl.ld;
      w_bus.st     = w_exc_any ? ST_NONE : w_ctrl.st;
      w_bus.md     = w_md;
      w_bus.waddr  = w_ctrl.waddr;
      w_bus.reg_en = w_ctrl.reg_en & ~w_exc_any;
      w_bus.ds     = r_ds;
      w_bus.exc    = w_exc[5:0];
    end
  end

  assign de_bus = w_bus;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_pc      <= '0;
      r_ds      <= 1'b0;
      r_br_pend <= 1'b0;
      r_md_busy <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (exc_flush)       r_valid <= 1'b0;
      else if (de_allowin) r_valid <= fe_valid;
      if (w_accept) begin
        r_inst <= fe_inst;
        r_pc   <= fe_pc;
      end
      // A branch may leave before its slot arrives; remember it.
      if (exc_flush) begin
        r_ds      <= 1'b0;
        r_br_pend <= 1'b0;
      end else if (w_accept) begin
        r_ds      <= (w_fire & w_br) | r_br_pend;
        r_br_pend <= 1'b0;
      end else if (w_fire & w_br) begin
        r_br_pend <= 1'b1;
      end
      if (w_fire & is_md_arith(w_md)) r_md_busy <= 1'b1;
      else if (wb_md_complete)        r_md_busy <= 1'b0;
      if (wb_md_complete)                    {r_hi, r_lo} <= wb_md_result;
      else if (w_fire && w_md == MD_MTHI)    r_hi <= rs_data;
      else if (w_fire && w_md == MD_MTLO)    r_lo <= rs_data;
    end
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: decode vector table plus
// hand sequences for hazards, mult/div, delay slot, flush and reset.
module tb_decode_stage_hs;
  import decode_stage_hs_pkg::*;

  logic                clk, resetn;
  logic                fe_valid;
  logic [31:0]         fe_inst, fe_pc;
  logic                de_allowin;
  logic [4:0]          rs_addr, rt_addr;
  logic [31:0]         rs_data, rt_data;
  logic                exe_valid, exe_is_load, mem_valid;
  logic [4:0]          exe_waddr, mem_waddr;
  logic                wb_md_complete;
  logic [63:0]         wb_md_result;
  logic                exe_allowin, de_to_exe_valid, de_md_busy;
  logic                exc_flush;
  logic [DE_BUS_W-1:0] de_bus;
  de_bus_t             b;

  int checks = 0;
  int errors = 0;

  assign b = de_bus_t'(de_bus);

  decode_stage_hs dut (
    .clk             (clk),
    .resetn          (resetn),
    .fe_valid        (fe_valid),
    .fe_inst         (fe_inst),
    .fe_pc           (fe_pc),
    .de_allowin      (de_allowin),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .exe_valid       (exe_valid),
    .exe_is_load     (exe_is_load),
    .exe_waddr       (exe_waddr),
    .mem_valid       (mem_valid),
    .mem_waddr       (mem_waddr),
    .wb_md_complete  (wb_md_complete),
    .wb_md_result    (wb_md_result),
    .exe_allowin     (exe_allowin),
    .de_to_exe_valid (de_to_exe_valid),
    .de_bus          (de_bus),
    .de_md_busy      (de_md_busy),
    .exc_flush       (exc_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  exc;
    logic        reg_en;
    logic [4:0]  waddr;
    logic [3:0]  alu;
    logic [31:0] imm;
  } vec_t;

  vec_t vt[13];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(logic [31:0] inst, logic [31:0] pc);
    fe_valid = 1'b1;
    fe_inst  = inst;
    fe_pc    = pc;
    tick();
    fe_valid = 1'b0;
    #1;
  endtask

  initial begin
    resetn = 0; fe_valid = 0; fe_inst = 0; fe_pc = 0;
    rs_data = 32'h1111_1111; rt_data = 32'h2222_2222;
    exe_valid = 0; exe_is_load = 0; exe_waddr = 0;
    mem_valid = 0; mem_waddr = 0;
    wb_md_complete = 0; wb_md_result = 0;
    exe_allowin = 1; exc_flush = 0;

    vt[0]  = '{"addu",  32'h00221821, 32'h1000, 6'b000000, 1, 5'd3,  ALU_ADD,  32'h0};
    vt[1]  = '{"addi",  32'h2024FFFF, 32'h1004, 6'b000100, 1, 5'd4,  ALU_ADD,  32'hFFFF_FFFF};
    vt[2]  = '{"ori",   32'h34058001, 32'h1008, 6'b000000, 1, 5'd5,  ALU_OR,   32'h8001};
    vt[3]  = '{"lw",    32'h8C260004, 32'h100C, 6'b000000, 1, 5'd6,  ALU_ADD,  32'h4};
    vt[4]  = '{"sw",    32'hAC260008, 32'h1010, 6'b000000, 0, 5'd6,  ALU_ADD,  32'h8};
    vt[5]  = '{"lui",   32'h3C071234, 32'h1014, 6'b000000, 1, 5'd7,  ALU_LUI,  32'h1234};
    vt[6]  = '{"jal",   32'h0C000100, 32'h1018, 6'b000000, 1, 5'd31, ALU_ADD,  32'h100};
    vt[7]  = '{"sll",   32'h000240C0, 32'h101C, 6'b000000, 1, 5'd8,  ALU_SLL,  32'h3};
    vt[8]  = '{"sub",   32'h00221822, 32'h1020, 6'b000100, 1, 5'd3,  ALU_SUB,  32'h0};
    vt[9]  = '{"sys",   32'h0000000C, 32'h1024, 6'b000010, 0, 5'd0,  ALU_ADD,  32'h0};
    vt[10] = '{"brk",   32'h0000000D, 32'h1028, 6'b000001, 0, 5'd0,  ALU_ADD,  32'h0};
    vt[11] = '{"ri3f",  32'hFC000000, 32'h102C, 6'b001000, 0, 5'd0,  ALU_ADD,  32'h0};
    vt[12] = '{"adel",  32'h00221821, 32'h1032, 6'b010000, 0, 5'd3,  ALU_ADD,  32'h0};

    // reset state
    #12;
    chk("rst_valid", de_to_exe_valid, 0);
    chk("rst_busy", de_md_busy, 0);
    chk("rst_bus", de_bus, 0);
    chk("rst_allowin", de_allowin, 0);
    tick();
    resetn = 1;
    #1;
    chk("rel_allowin", de_allowin, 1);

    // decode table, back to back
    foreach (vt[i]) begin
      offer(vt[i].inst, vt[i].pc);
      chk({vt[i].name, ".vld"}, de_to_exe_valid, 1);
      chk({vt[i].name, ".exc"}, b.exc, vt[i].exc);
      chk({vt[i].name, ".reg_en"}, b.reg_en, vt[i].reg_en);
      chk({vt[i].name, ".waddr"}, b.waddr, vt[i].waddr);
      chk({vt[i].name, ".alu"}, b.aluop, vt[i].alu);
      chk({vt[i].name, ".imm"}, b.imm, vt[i].imm);
      chk({vt[i].name, ".pc"}, b.pc, vt[i].pc);
    end
    tick();
    chk("drain_bus", de_bus, 0);

    // load-use: ADDU $6,$5,$1 behind LW $5
    exe_valid = 1; exe_is_load = 1; exe_waddr = 5'd5;
    offer(32'h00A13021, 32'h2000);
    chk("lu_rs", rs_addr, 5);
    chk("lu_stall", de_to_exe_valid, 0);
    chk("lu_allowin", de_allowin, 0);
    exe_valid = 0; mem_valid = 1; mem_waddr = 5'd5;
    #1;
    chk("lu_go", de_to_exe_valid, 1);
    tick();
    mem_valid = 0;
    // $0 target never hazards; non-load EXE hit forwards
    exe_valid = 1; exe_is_load = 1; exe_waddr = 5'd0;
    offer(32'h00013021, 32'h2004);
    chk("zero_nostall", de_to_exe_valid, 1);
    exe_is_load = 0; exe_waddr = 5'd5;
    offer(32'h00A13021, 32'h2008);
    chk("fwd_nostall", de_to_exe_valid, 1);
    exe_valid = 0; exe_waddr = 0;
    tick();

    // MULT then MFLO waits for completion
    offer(32'h00220018, 32'h3000);
    chk("mult_vld", de_to_exe_valid, 1);
    offer(32'h00001812, 32'h3004);
    chk("md_busy", de_md_busy, 1);
    chk("mflo_stall", de_to_exe_valid, 0);
    tick();
    chk("mflo_stall2", de_to_exe_valid, 0);
    wb_md_complete = 1;
    wb_md_result = 64'h0000_0002_0000_0003;
    tick();
    wb_md_complete = 0;
    #1;
    chk("md_done", de_md_busy, 0);
    chk("mflo_go", de_to_exe_valid, 1);
    chk("mflo_src", b.src1, 32'h3);
    offer(32'h00001810, 32'h3008);
    chk("mfhi_src", b.src1, 32'h2);
    tick();

    // delay slot after BEQ
    offer(32'h10220004, 32'h4000);
    chk("beq_ds", b.ds, 0);
    offer(32'h24030001, 32'h4004);
    chk("addiu_ds", b.ds, 1);
    offer(32'h00221821, 32'h4008);
    chk("next_ds", b.ds, 0);
    tick();

    // flush with an offer in the same cycle
    offer(32'h00221821, 32'h5000);
    fe_valid = 1; fe_inst = 32'h34058001; fe_pc = 32'h5004;
    exc_flush = 1;
    #1;
    chk("fl_suppress", de_to_exe_valid, 0);
    tick();
    fe_valid = 0; exc_flush = 0;
    #1;
    chk("fl_vld", de_to_exe_valid, 0);
    chk("fl_bus", de_bus, 0);
    chk("fl_allowin", de_allowin, 1);

    // flush keeps mult/div busy
    offer(32'h00220018, 32'h5100);
    tick();
    chk("fl_md_pre", de_md_busy, 1);
    exc_flush = 1;
    tick();
    exc_flush = 0;
    chk("fl_md_keep", de_md_busy, 1);
    wb_md_complete = 1; wb_md_result = 64'h9;
    tick();
    wb_md_complete = 0;
    chk("fl_md_clr", de_md_busy, 0);

    // reset mid-stall
    offer(32'h00220018, 32'h6000);
    offer(32'h00001812, 32'h6004);
    chk("rs_stall", de_to_exe_valid, 0);
    chk("rs_busy_pre", de_md_busy, 1);
    #2;
    resetn = 0;
    #1;
    chk("rs_vld", de_to_exe_valid, 0);
    chk("rs_busy", de_md_busy, 0);
    chk("rs_bus", de_bus, 0);
    chk("rs_allowin", de_allowin, 0);
    tick();
    tick();
    resetn = 1;
    #1;
    chk("rs_rel_allowin", de_allowin, 1);
    // stale completion still loads HI/LO
    wb_md_complete = 1;
    wb_md_result = 64'h0000_0005_0000_0007;
    tick();
    wb_md_complete = 0;
    offer(32'h00001810, 32'h6100);
    chk("post_rs_vld", de_to_exe_valid, 1);
    chk("post_rs_hi", b.src1, 32'h5);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
